uart_tx_path: RTL and testbench

UART transmitter for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. It is the send-side counterpart of the team's UART receive path. Bytes arrive over a valid/ready handshake and are serialised onto uart_tx_o. Bit timing uses the same baud divider convention as the receiver, so the two ends loop back directly.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_tx_path.sv | 138 +++++++++++++
 tb/tb_uart_tx_path.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// state encoding, frame geometry and the default baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with full/empty flags and first-word-fall-through read data.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is data only; it needs no reset because the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_path.sv
// 8N1 UART transmitter. Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry
// FIFO ahead of the shifter (back-to-back frames); otherwise one holding slot.
module uart_tx_path
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DATA_BITS-1:0] uart_tx_data_i,
  input  logic                 uart_tx_valid_i,
  output logic                 uart_tx_ready_o,
  output logic                 uart_tx_o,
  output logic                 uart_tx_busy_o,
  output logic                 uart_tx_done
);

  localparam logic [13:0] BAUD_LAST = 14'(BAUD_DIV);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [13:0]          baud_cnt;
  logic [13:0]          baud_cnt_nxt;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 line_nxt;
  logic                 bit_end;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;
  logic                 take;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en   (uart_tx_valid_i && !fifo_full),
    .wr_data (uart_tx_data_i),
    .rd_en   (take),
    .rd_data (load_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign load            = !fifo_empty;
  assign uart_tx_ready_o = !fifo_full;
`else
  logic unused_fifo_depth;

  assign unused_fifo_depth = |FIFO_DEPTH;
  assign load              = uart_tx_valid_i && (state == IDLE);
  assign load_data         = uart_tx_data_i;
  assign uart_tx_ready_o   = (state == IDLE);
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);
  // The shifter takes a new byte from IDLE, or straight out of the stop bit.
  assign take    = load && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      uart_tx_o <= line_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_reg <= shift_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift_reg;
    baud_cnt_nxt = ((state == IDLE) || bit_end) ? 14'd0 : baud_cnt + 14'd1;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = START;
          shift_nxt = load_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (take) begin
            state_nxt = START;
            shift_nxt = load_data;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is computed from the next state so the flop shows it on the
  // first cycle of that state.
  always_comb begin
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      default: line_nxt = 1'b1;
    endcase
    uart_tx_busy_o = (state != IDLE);
    uart_tx_done   = (state == STOP) && bit_end;
  end

endmodule

// File: tb/tb_uart_tx_path.sv
// Randomised self-checking bench for uart_tx_path: a frame-level reference
// model, a behavioural serial receiver and a few literal frame checks.
`timescale 1ns/1ps
module tb_uart_tx_path;

  localparam int BAUD_DIV   = 9;
  localparam int P          = BAUD_DIV + 1;
  localparam int FL         = 10 * P;
  localparam int FIFO_DEPTH = 16;
`ifdef UART_TX_FIFO_EN
  localparam int START_LAT  = 1;
`else
  localparam int START_LAT  = 0;
`endif

  logic       clk_i;
  logic       rst_n_i;
  logic [7:0] uart_tx_data_i;
  logic       uart_tx_valid_i;
  logic       uart_tx_ready_o;
  logic       uart_tx_o;
  logic       uart_tx_busy_o;
  logic       uart_tx_done;

  uart_tx_path #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .uart_tx_data_i  (uart_tx_data_i),
    .uart_tx_valid_i (uart_tx_valid_i),
    .uart_tx_ready_o (uart_tx_ready_o),
    .uart_tx_o       (uart_tx_o),
    .uart_tx_busy_o  (uart_tx_busy_o),
    .uart_tx_done    (uart_tx_done)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one frame in flight plus a queue of bytes waiting for it.
  bit         m_active;
  int         m_fcyc;
  logic [7:0] m_cur;
  logic [7:0] m_pend[$];
  logic [7:0] m_sent[$];
  int         m_cyc = 0;
  int         acc_cyc[$];

  function automatic bit m_ready();
`ifdef UART_TX_FIFO_EN
    return m_pend.size() < FIFO_DEPTH;
`else
    return !m_active;
`endif
  endfunction

  function automatic logic m_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_fcyc / P;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  initial begin
    m_active = 1'b0;
    m_fcyc   = 0;
    forever begin
      bit         acc;
      bit         last;
      logic [7:0] d;
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
        m_active = 1'b0;
        m_fcyc   = 0;
        m_pend.delete();
        m_sent.delete();
      end else begin
        acc  = uart_tx_valid_i && m_ready();
        d    = uart_tx_data_i;
        last = m_active && (m_fcyc == FL - 1);
`ifdef UART_TX_FIFO_EN
        if (m_active && !last) m_fcyc++;
        else if (m_pend.size() > 0) begin
          m_cur    = m_pend.pop_front();
          m_active = 1'b1;
          m_fcyc   = 0;
        end else m_active = 1'b0;
        if (acc) m_pend.push_back(d);
`else
        if (m_active) begin
          if (last) m_active = 1'b0;
          else      m_fcyc++;
        end else if (acc) begin
          m_cur    = d;
          m_active = 1'b1;
          m_fcyc   = 0;
        end
`endif
        if (acc) begin
          m_sent.push_back(d);
          acc_cyc.push_back(m_cyc);
        end
        m_cyc++;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i) begin
      chk("rst_line", uart_tx_o, 1);
      chk("rst_busy", uart_tx_busy_o, 0);
      chk("rst_done", uart_tx_done, 0);
    end else begin
      chk("line", uart_tx_o, m_line());
      chk("busy", uart_tx_busy_o, m_active);
      chk("done", uart_tx_done, m_active && (m_fcyc == FL - 1));
      chk("ready", uart_tx_ready_o, m_ready());
    end
  end

  // Behavioural receiver: mid-bit sampling, checks against accepted bytes.
  bit         rx_on = 1'b0;
  int         rx_cnt;
  logic [7:0] rx_sh;
  logic [7:0] rx_log[$];

  initial forever begin
    int k;
    @(negedge clk_i);
    if (!rst_n_i) rx_on = 1'b0;
    else begin
      if (!rx_on && uart_tx_o === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
      if (rx_on) begin
        if (rx_cnt % P == P / 2) begin
          k = rx_cnt / P;
          if (k == 0) chk("rx_start_bit", uart_tx_o, 0);
          else if (k < 9) rx_sh[k-1] = uart_tx_o;
          else begin
            chk("rx_stop_bit", uart_tx_o, 1);
            rx_log.push_back(rx_sh);
            chk("rx_byte_expected", m_sent.size() > 0, 1);
            if (m_sent.size() > 0) chk("rx_byte", rx_sh, m_sent.pop_front());
            rx_on = 1'b0;
          end
        end
        rx_cnt++;
      end
    end
  end

  int run_len  = 0;
  int last_run = 0;
  bit saw_ready_low = 1'b0;

  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i) run_len = 0;
    else begin
      if (!uart_tx_ready_o) saw_ready_low = 1'b1;
      if (uart_tx_busy_o) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input int max_wait);
    int w = 0;
    uart_tx_valid_i = 1'b1;
    uart_tx_data_i  = b;
    while (!uart_tx_ready_o && w < max_wait) begin
      @(negedge clk_i);
      w++;
    end
    chk("send_wait_bound", w < max_wait, 1);
    @(negedge clk_i);
    uart_tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int w = 0;
    int q = 0;
    while (q < 2 && w < max_cyc) begin
      @(negedge clk_i);
      if (!uart_tx_busy_o) q++;
      else q = 0;
      w++;
    end
    chk("idle_wait_bound", q >= 2, 1);
  endtask

  task automatic wait_busy(output int w);
    w = 0;
    while (!uart_tx_busy_o && w < 10) begin
      @(negedge clk_i);
      w++;
    end
  endtask

  logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int   lat;
  int   first_acc;
  int   n_rx_before;

  initial begin
    rst_n_i         = 1'b0;
    uart_tx_valid_i = 1'b0;
    uart_tx_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_release", uart_tx_ready_o, 1);

    // Single byte 0xA5 against literal line levels.
    send(8'hA5, 10);
    wait_busy(lat);
    chk("start_latency", lat, START_LAT);
    for (int i = 0; i < FL; i++) begin
      chk("a5_line", uart_tx_o, a5_bits[i / P]);
      chk("a5_done", uart_tx_done, i == FL - 1);
      @(negedge clk_i);
    end
    chk("a5_idle_line", uart_tx_o, 1);
    chk("a5_idle_busy", uart_tx_busy_o, 0);
    wait_idle(50);

`ifndef UART_TX_FIFO_EN
    // Hold-off: valid during a frame must not be accepted.
    send(8'h0F, 10);
    first_acc = acc_cyc[$];
    repeat (30) @(negedge clk_i);
    uart_tx_valid_i = 1'b1;
    uart_tx_data_i  = 8'h3C;
    repeat (5) begin
      chk("holdoff_ready", uart_tx_ready_o, 0);
      @(negedge clk_i);
    end
    uart_tx_data_i = 8'hC3;
    repeat (3) begin
      chk("holdoff_ready", uart_tx_ready_o, 0);
      @(negedge clk_i);
    end
    uart_tx_valid_i = 1'b0;
    send(8'hC3, 200);
    chk("holdoff_accept_gap", acc_cyc[$] - first_acc, FL + 1);
    wait_idle(300);
    chk("holdoff_rx_first", rx_log[$-1], 8'h0F);
    chk("holdoff_rx_second", rx_log[$], 8'hC3);
`else
    // Back-to-back through the FIFO, then fill it until ready drops.
    send(8'h00, 10);
    send(8'hFF, 10);
    send(8'h55, 10);
    wait_idle(400);
    chk("b2b_busy_run", last_run, 3 * FL);
    saw_ready_low = 1'b0;
    for (int i = 0; i < 20; i++) send(8'(i * 7 + 1), 400);
    chk("fifo_ready_dropped", saw_ready_low, 1);
    wait_idle(3000);
`endif

    // Random stream with random gaps.
    repeat (30) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk_i);
      send(8'($urandom), 400);
    end
    wait_idle(4000);

    // Reset during data bit 3 of 0x81, then a clean 0x42.
    send(8'h81, 400);
    wait_busy(lat);
    repeat (4 * P + 4) @(negedge clk_i);
    chk("pre_reset_line", uart_tx_o, 0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("reset_line_now", uart_tx_o, 1);
    chk("reset_busy_now", uart_tx_busy_o, 0);
    chk("reset_done_now", uart_tx_done, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rerelease", uart_tx_ready_o, 1);
    n_rx_before = rx_log.size();
    send(8'h42, 10);
    wait_idle(300);
    chk("post_reset_rx_count", rx_log.size() - n_rx_before, 1);
    chk("post_reset_rx_byte", rx_log[$], 8'h42);

    chk("all_bytes_received", m_sent.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
